// File: rtl/mutex_client_master.sv
// mutex_client_master
// Avalon-MM master that takes and gives back a hardware mutex for a local
// engine, so no CPU is needed. It writes {OWNER_ID, LOCK_VALUE} to mutex word 0
// and reads the word back. If the read returns the same word, the mutex is held.
// If not, the master waits RETRY_DELAY idle cycles and tries again.
// MAX_TRIES = 0 means it retries forever.
//
// Ports
//   clk, reset        : clock and asynchronous active-high reset
//   acquire_req       : one-cycle pulse, start an acquire (acted on only in IDLE)
//   release_req       : one-cycle pulse, release the mutex (acted on only in HELD)
//   abort             : level, abandon the acquire while in BACKOFF
//   granted           : high while this master holds the mutex
//   busy              : high in every state except IDLE and HELD
//   fail              : one-cycle pulse when tries run out or an abort completes
//   avm_*             : Avalon-MM master port (word addressed)
module mutex_client_master #(
    parameter logic [15:0] OWNER_ID    = 16'h0001,
    parameter logic [15:0] LOCK_VALUE  = 16'h0001,
    parameter int unsigned RETRY_DELAY = 16,
    parameter int unsigned MAX_TRIES   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        acquire_req,
    input  logic        release_req,
    input  logic        abort,
    output logic        granted,
    output logic        busy,
    output logic        fail,
    output logic        avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam int unsigned CNT_W     = 16;
    localparam logic [31:0] LOCK_WORD = {OWNER_ID, LOCK_VALUE};
    localparam logic [31:0] REL_WORD  = {OWNER_ID, 16'h0000};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LOCK,
        S_RD_CHECK,
        S_BACKOFF,
        S_HELD,
        S_WR_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   try_q, try_d;
    logic [CNT_W-1:0]   delay_q, delay_d;
    logic               granted_q, granted_d;
    logic               busy_q, busy_d;
    logic               fail_q, fail_d;
    logic               address_q, address_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [31:0]        wdata_q, wdata_d;

    // Next state, counters, and the registered copy of every output.
    // Outputs are decoded from the next state, so each one is valid during
    // the cycle its state is active.
    always_comb begin
        state_d   = state_q;
        try_d     = try_q;
        delay_d   = delay_q;
        fail_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (acquire_req) begin
                    state_d = S_WR_LOCK;
                    try_d   = CNT_W'(1);
                end
            end
            S_WR_LOCK: begin
                if (!avm_waitrequest) state_d = S_RD_CHECK;
            end
            S_RD_CHECK: begin
                // Readdata is used only on the cycle the read completes.
                if (!avm_waitrequest) begin
                    if (avm_readdata == LOCK_WORD) begin
                        state_d = S_HELD;
                    end else begin
                        state_d = S_BACKOFF;
                        delay_d = CNT_W'(RETRY_DELAY);
                    end
                end
            end
            S_BACKOFF: begin
                if (delay_q != '0) delay_d = delay_q - CNT_W'(1);
                // Abort wins over counter expiry.
                if (abort) begin
                    state_d = S_IDLE;
                    fail_d  = 1'b1;
                end else if (delay_q <= CNT_W'(1)) begin
                    if ((MAX_TRIES != 0) && (try_q == CNT_W'(MAX_TRIES))) begin
                        state_d = S_IDLE;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = S_WR_LOCK;
                        if (try_q != '1) try_d = try_q + CNT_W'(1);
                    end
                end
            end
            S_HELD: begin
                if (release_req) state_d = S_WR_RELEASE;
            end
            S_WR_RELEASE: begin
                if (!avm_waitrequest) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        granted_d = (state_d == S_HELD);
        busy_d    = (state_d != S_IDLE) && (state_d != S_HELD);
        read_d    = (state_d == S_RD_CHECK);
        write_d   = (state_d == S_WR_LOCK) || (state_d == S_WR_RELEASE);
        address_d = 1'b0;
        wdata_d   = 32'h0;
        if (state_d == S_WR_LOCK)    wdata_d = LOCK_WORD;
        if (state_d == S_WR_RELEASE) wdata_d = REL_WORD;
    end

    // State and output registers. Reset drops any transfer at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            try_q     <= '0;
            delay_q   <= '0;
            granted_q <= 1'b0;
            busy_q    <= 1'b0;
            fail_q    <= 1'b0;
            address_q <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            try_q     <= try_d;
            delay_q   <= delay_d;
            granted_q <= granted_d;
            busy_q    <= busy_d;
            fail_q    <= fail_d;
            address_q <= address_d;
            read_q    <= read_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
        end
    end

    assign granted       = granted_q;
    assign busy          = busy_q;
    assign fail          = fail_q;
    assign avm_address   = address_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;

endmodule

// File: tb/tb_mutex_client_master.sv
// Bench for mutex_client_master, configured with MAX_TRIES = 3 and
// RETRY_DELAY = 16. A directed vector table covers the main paths, and
// hand-written sequences cover backoff timing, try exhaustion, and reset
// arriving in the middle of a transfer.
module tb_mutex_client_master;

    localparam logic [31:0] LOCK_W  = 32'h0001_0001;
    localparam logic [31:0] REL_W   = 32'h0001_0000;
    localparam logic [31:0] OTHER_W = 32'h0002_0005;

    logic        clk = 1'b0;
    logic        reset;
    logic        acquire_req, release_req, abort;
    logic        granted, busy, fail;
    logic        avm_address, avm_read, avm_write, avm_waitrequest;
    logic [31:0] avm_writedata, avm_readdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mutex_client_master #(
        .OWNER_ID   (16'h0001),
        .LOCK_VALUE (16'h0001),
        .RETRY_DELAY(16),
        .MAX_TRIES  (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .acquire_req    (acquire_req),
        .release_req    (release_req),
        .abort          (abort),
        .granted        (granted),
        .busy           (busy),
        .fail           (fail),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    typedef struct {
        logic        acq, rel, ab, wt;
        logic [31:0] rd;
        logic        g, b, f, r, w;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs are applied on the falling edge. Outputs are sampled 1 time unit
    // after the next rising edge.
    task automatic step(input logic a, input logic r, input logic ab, input logic wt,
                        input logic [31:0] rd);
        @(negedge clk);
        acquire_req     = a;
        release_req     = r;
        abort           = ab;
        avm_waitrequest = wt;
        avm_readdata    = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, bus, wr_n, rd_n, f_n, g_n, post;

        reset = 1'b1;
        acquire_req = 1'b0; release_req = 1'b0; abort = 1'b0;
        avm_waitrequest = 1'b0; avm_readdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst granted", 32'(granted), 32'd0);
        chk("rst busy",    32'(busy),    32'd0);
        chk("rst fail",    32'(fail),    32'd0);
        chk("rst read",    32'(avm_read), 32'd0);
        chk("rst write",   32'(avm_write), 32'd0);
        chk("rst addr",    32'(avm_address), 32'd0);
        chk("rst wdata",   avm_writedata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        //                acq rel ab wt  rd        g  b  f  r  w  wd
        vecs.push_back('{1, 0, 0, 0, 32'h0,    0, 1, 0, 0, 1, LOCK_W}); // acquire -> write
        vecs.push_back('{0, 0, 0, 0, 32'h0,    0, 1, 0, 1, 0, 32'h0});  // read
        vecs.push_back('{0, 0, 0, 0, LOCK_W,   1, 0, 0, 0, 0, 32'h0});  // match -> held
        vecs.push_back('{0, 0, 0, 0, 32'h0,    1, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{1, 0, 0, 0, 32'h0,    1, 0, 0, 0, 0, 32'h0});  // acquire ignored in HELD
        vecs.push_back('{0, 1, 0, 0, 32'h0,    0, 1, 0, 0, 1, REL_W});  // release write
        vecs.push_back('{1, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0});  // acq in WR_RELEASE ignored
        vecs.push_back('{0, 0, 0, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0});
        vecs.push_back('{1, 0, 0, 1, 32'h0,    0, 1, 0, 0, 1, LOCK_W}); // write, then stalled
        for (int i = 0; i < 5; i++)
            vecs.push_back('{0, 0, 0, 1, LOCK_W, 0, 1, 0, 0, 1, LOCK_W});
        vecs.push_back('{0, 0, 0, 0, 32'h0,    0, 1, 0, 1, 0, 32'h0});  // write completes
        for (int i = 0; i < 5; i++)                                     // stalled read, match ignored
            vecs.push_back('{0, 0, 0, 1, LOCK_W, 0, 1, 0, 1, 0, 32'h0});
        vecs.push_back('{0, 0, 0, 0, OTHER_W,  0, 1, 0, 0, 0, 32'h0});  // mismatch -> backoff
        vecs.push_back('{0, 0, 1, 0, 32'h0,    0, 0, 1, 0, 0, 32'h0});  // abort -> fail pulse
        vecs.push_back('{0, 1, 1, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0});  // release/abort idle ignored

        foreach (vecs[i]) begin
            step(vecs[i].acq, vecs[i].rel, vecs[i].ab, vecs[i].wt, vecs[i].rd);
            chk($sformatf("v%0d granted", i), 32'(granted),   32'(vecs[i].g));
            chk($sformatf("v%0d busy", i),    32'(busy),      32'(vecs[i].b));
            chk($sformatf("v%0d fail", i),    32'(fail),      32'(vecs[i].f));
            chk($sformatf("v%0d read", i),    32'(avm_read),  32'(vecs[i].r));
            chk($sformatf("v%0d write", i),   32'(avm_write), 32'(vecs[i].w));
            chk($sformatf("v%0d addr", i),    32'(avm_address), 32'd0);
            chk($sformatf("v%0d wdata", i),   avm_writedata, vecs[i].wd);
        end

        // Backoff of 16 cycles, then a successful retry.
        step(1, 0, 0, 0, 32'h0);
        chk("bo first write", 32'(avm_write), 32'd1);
        step(0, 0, 0, 0, 32'h0);
        chk("bo first read", 32'(avm_read), 32'd1);
        step(0, 0, 0, 0, OTHER_W);
        chk("bo busy", 32'(busy), 32'd1);
        k = 0; bus = 0;
        while (!avm_write && k < 40) begin
            step(0, 0, 0, 0, OTHER_W);
            k++;
            if (!avm_write) bus += 32'(avm_read);
        end
        chk("bo cycles to 2nd write", 32'(k), 32'd16);
        chk("bo bus quiet", 32'(bus), 32'd0);
        chk("bo 2nd wdata", avm_writedata, LOCK_W);
        step(0, 0, 0, 0, 32'h0);
        chk("bo 2nd read", 32'(avm_read), 32'd1);
        step(0, 0, 0, 0, LOCK_W);
        chk("bo granted", 32'(granted), 32'd1);
        chk("bo busy after grant", 32'(busy), 32'd0);
        step(0, 1, 0, 0, 32'h0);
        chk("bo release granted", 32'(granted), 32'd0);
        chk("bo release wdata", avm_writedata, REL_W);
        step(0, 0, 0, 0, 32'h0);
        chk("bo idle busy", 32'(busy), 32'd0);

        // Try exhaustion: the mutex stays owned by another master.
        wr_n = 0; rd_n = 0; f_n = 0; g_n = 0; post = 0;
        step(1, 0, 0, 0, OTHER_W);
        for (int i = 0; i < 300 && post < 6; i++) begin
            wr_n += 32'(avm_write);
            rd_n += 32'(avm_read);
            f_n  += 32'(fail);
            g_n  += 32'(granted);
            if (f_n > 0) post++;
            step(0, 0, 0, 0, OTHER_W);
        end
        chk("mt writes", 32'(wr_n), 32'd3);
        chk("mt reads",  32'(rd_n), 32'd3);
        chk("mt fail pulses", 32'(f_n), 32'd1);
        chk("mt granted never", 32'(g_n), 32'd0);
        chk("mt busy end", 32'(busy), 32'd0);

        // Reset during RD_CHECK, then a normal acquire.
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        chk("rc in read", 32'(avm_read), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rc read dropped", 32'(avm_read), 32'd0);
        chk("rc busy dropped", 32'(busy), 32'd0);
        chk("rc write low", 32'(avm_write), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 0, 0, 0, 32'h0);
        chk("rc c1 write", 32'(avm_write), 32'd1);
        step(0, 0, 0, 0, 32'h0);
        chk("rc c2 read", 32'(avm_read), 32'd1);
        chk("rc c2 granted", 32'(granted), 32'd0);
        step(0, 0, 0, 0, LOCK_W);
        chk("rc c3 granted", 32'(granted), 32'd1);
        chk("rc c3 busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mutex_client_master.md
Name: mutex_client_master

Overview:
- Avalon-MM master that acquires and releases a hardware mutex slave on behalf of a local hardware engine, so no CPU is involved.
- Mutex slave register map:
  - word 0 = {owner[31:16], value[15:0]}; a write takes effect only if value==0 or the written owner matches the stored owner.
  - word 1 = reset flag.
- Sits between a DMA/packet engine and the system interconnect, alongside CPU masters contending for the same mutex.

Parameters:
- OWNER_ID, 16'h0001, owner tag written to bits [31:16]; must be nonzero and unique per master.
- LOCK_VALUE, 16'h0001, value written to bits [15:0] on acquire; must be nonzero.
- RETRY_DELAY, 16, idle cycles in BACKOFF between failed attempts (1..65535).
- MAX_TRIES, 0, acquire attempts before giving up; 0 = retry forever.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- acquire_req  in  1  one-cycle pulse: start acquire
- release_req  in  1  one-cycle pulse: release held mutex
- abort  in  1  level: abandon acquire while in BACKOFF
- granted  out  1  high while mutex is held by this master
- busy  out  1  high in any state except IDLE and HELD
- fail  out  1  one-cycle pulse when MAX_TRIES is exhausted or an abort completes
- avm_address  out  1  word address (0 = mutex, 1 = reset flag)
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_writedata  out  32  write data
- avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest
- avm_waitrequest  in  1  slave stall

Behaviour:
- Reset: state=IDLE; granted, busy, fail, avm_read, avm_write = 0; avm_address = 0; avm_writedata = 0; try counter and delay counter = 0. Reset asserted mid-transaction drops avm_read/avm_write immediately; no completion is attempted.
- States: IDLE, WR_LOCK, RD_CHECK, BACKOFF, HELD, WR_RELEASE.
- IDLE
  - acquire_req -> WR_LOCK; try counter = 1.
  - release_req is ignored.
- WR_LOCK
  - avm_write=1, avm_address=0, avm_writedata={OWNER_ID,LOCK_VALUE}.
  - Hold all master outputs stable while avm_waitrequest=1.
  - First cycle with waitrequest=0 completes the write -> RD_CHECK.
- RD_CHECK
  - avm_read=1, avm_address=0.
  - On the completing cycle, compare avm_readdata to {OWNER_ID,LOCK_VALUE}.
  - Match -> HELD; granted=1 from the next cycle.
  - Mismatch -> BACKOFF; delay counter = RETRY_DELAY.
- BACKOFF
  - No bus activity; delay counter decrements each cycle.
  - abort=1 -> IDLE with a fail pulse; abort takes priority over expiry.
  - Counter reaches 0 and MAX_TRIES!=0 and try counter==MAX_TRIES -> IDLE with a fail pulse.
  - Counter reaches 0 otherwise -> WR_LOCK; try counter +1, saturating at 16 bits.
- HELD
  - granted=1, busy=0.
  - release_req -> WR_RELEASE; granted falls in the same cycle WR_RELEASE is entered.
  - acquire_req is ignored.
- WR_RELEASE
  - avm_write=1, avm_address=0, avm_writedata={OWNER_ID,16'h0000}.
  - On completion -> IDLE.
- Pulses arriving while busy=1 are ignored (not queued), except abort in BACKOFF.
- acquire_req and release_req in the same cycle: only the one valid for the current state acts.
- At most one of avm_read and avm_write is asserted in any cycle.
- All outputs are registered.
- Zero-wait-state latency: acquire_req at cycle 0 -> write at cycle 1 -> read at cycle 2 -> granted=1 at cycle 3.
- fail is exactly one cycle wide; granted and fail never assert together.

Test Plan:
- Free mutex, waitrequest=0: acquire_req at cycle 0 -> write 32'h0001_0001 at cycle 1, read at cycle 2 with readdata 32'h0001_0001, granted=1 at cycle 3, busy=0.
- Mutex owned by another master (readdata 32'h0002_0005): -> BACKOFF for 16 cycles, second write at cycle 3+16; on a subsequent matching read -> granted=1.
- MAX_TRIES=3 with readdata always 32'h0002_0005: -> exactly 3 writes and 3 reads, then one fail pulse, state IDLE, granted=0.
- In HELD, release_req -> granted=0 next cycle, single write of 32'h0001_0000 to address 0, then IDLE; an acquire_req during WR_RELEASE causes no bus activity.
- waitrequest held high for 5 cycles during WR_LOCK and RD_CHECK -> address, writedata and read/write held stable, no extra transfers, grant decision taken only on the completing cycle.
- reset asserted while in RD_CHECK -> avm_read=0 and busy=0 immediately; after release, acquire_req gives normal cycle-3 grant timing.
